// File: rtl/unpadding_pkg.sv
// Shared types and helpers for the unpadding stream cropper and its padding counterpart.
package unpadding_pkg;

  typedef enum logic [1:0] {
    TOP_BOTTOM = 2'd0,
    SIDE       = 2'd1,
    INTERIOR   = 2'd2
  } frame_pos_e;

  // One extra bit beyond clog2 keeps the wrap compare free of overflow.
  function automatic int coord_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/unpadding_skid_buffer.sv
// Two-entry output register slice: registered data/valid plus one skid entry so that
// ready toward the producer is itself a registered signal.
module unpadding_skid_buffer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [DATA_WIDTH-1:0] skid_data;
  logic                  skid_valid;

  assign in_ready = !skid_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end
    end else if (in_valid && !skid_valid) begin
      // Output is stalled: park the accepted element in the skid entry.
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/unpadding.sv
// Crops a fixed border from a channel-interleaved padded frame and forwards the interior.
// Optional macro UNPADDING_ZERO_CHECK_EN builds the non-zero border detector behind pad_error.
module unpadding
  import unpadding_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int IMG_WIDTH      = 4,
  parameter int IMG_HEIGHT     = 3,
  parameter int PADDING_WIDTH  = 2,
  parameter int PADDING_HEIGHT = 2,
  parameter int CHANNELS       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic                  frame_done,
  output logic                  pad_error
);

  localparam int PAD_W_TOT = IMG_WIDTH + 2 * PADDING_WIDTH;
  localparam int PAD_H_TOT = IMG_HEIGHT + 2 * PADDING_HEIGHT;
  localparam int CW = coord_width(CHANNELS);
  localparam int XW = coord_width(PAD_W_TOT);
  localparam int YW = coord_width(PAD_H_TOT);

  localparam logic [CW-1:0] C_LAST = CW'(CHANNELS - 1);
  localparam logic [XW-1:0] X_LAST = XW'(PAD_W_TOT - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(PAD_H_TOT - 1);
  localparam logic [XW-1:0] X_LO   = XW'(PADDING_WIDTH);
  localparam logic [XW-1:0] X_HI   = XW'(PADDING_WIDTH + IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LO   = YW'(PADDING_HEIGHT);
  localparam logic [YW-1:0] Y_HI   = YW'(PADDING_HEIGHT + IMG_HEIGHT - 1);

  logic [CW-1:0] count_c;
  logic [XW-1:0] count_x;
  logic [YW-1:0] count_y;
  logic          x_before, y_before;
  frame_pos_e    frame_pos;
  logic          border, in_fire, push, last_elem, skid_ready;

  // With no border on a side, the lower bound test would be a constant-false compare.
  if (PADDING_WIDTH == 0) begin : g_no_left
    assign x_before = 1'b0;
  end else begin : g_left
    assign x_before = (count_x < X_LO);
  end

  if (PADDING_HEIGHT == 0) begin : g_no_top
    assign y_before = 1'b0;
  end else begin : g_top
    assign y_before = (count_y < Y_LO);
  end

  always_comb begin
    frame_pos = INTERIOR;
    if (y_before || (count_y > Y_HI))      frame_pos = TOP_BOTTOM;
    else if (x_before || (count_x > X_HI)) frame_pos = SIDE;
  end

  // Valid/ready: an element transfers on a cycle where valid and ready are both high;
  // border elements are always accepted and dropped, interior ones wait for the slice.
  assign border        = (frame_pos != INTERIOR);
  assign data_in_ready = border || skid_ready;
  assign in_fire       = data_in_valid && data_in_ready;
  assign push          = data_in_valid && !border;
  assign last_elem     = (count_c == C_LAST) && (count_x == X_LAST) && (count_y == Y_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_c    <= '0;
      count_x    <= '0;
      count_y    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= in_fire && last_elem;
      if (in_fire) begin
        if (count_c == C_LAST) begin
          count_c <= '0;
          if (count_x == X_LAST) begin
            count_x <= '0;
            count_y <= (count_y == Y_LAST) ? '0 : count_y + YW'(1);
          end else begin
            count_x <= count_x + XW'(1);
          end
        end else begin
          count_c <= count_c + CW'(1);
        end
      end
    end
  end

`ifdef UNPADDING_ZERO_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                      pad_error <= 1'b0;
    else if (in_fire && border && (data_in != '0)) pad_error <= 1'b1;
  end
`else
  assign pad_error = 1'b0;
`endif

  unpadding_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_slice (
    .clk      (clk),
    .rst      (rst),
    .in_data  (data_in),
    .in_valid (push),
    .in_ready (skid_ready),
    .out_data (data_out),
    .out_valid(data_out_valid),
    .out_ready(data_out_ready)
  );

endmodule

// File: tb/tb_unpadding.sv
// Bench for unpadding: default-geometry instance against a queue model, plus a
// zero-padding instance checked as a one-cycle pass-through.
module tb_unpadding;

  localparam int DW = 32, IW = 4, IH = 3, PW = 2, PH = 2, CH = 2;
  localparam int PWT    = IW + 2 * PW;
  localparam int PHT    = IH + 2 * PH;
  localparam int FRAME  = PWT * PHT * CH;
  localparam int PFRAME = IW * IH * CH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] data_in, data_out;
  logic          data_in_valid, data_in_ready, data_out_valid, data_out_ready;
  logic          frame_done, pad_error;

  logic [DW-1:0] p_data, p_out_data;
  logic          p_valid, p_in_ready, p_out_valid, p_fd, p_pad_error;
  logic          p_out_ready = 1'b1;

  unpadding #(
    .DATA_WIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH),
    .PADDING_WIDTH(PW), .PADDING_HEIGHT(PH), .CHANNELS(CH)
  ) dut (
    .clk(clk), .rst(rst),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
    .frame_done(frame_done), .pad_error(pad_error)
  );

  unpadding #(
    .DATA_WIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH),
    .PADDING_WIDTH(0), .PADDING_HEIGHT(0), .CHANNELS(CH)
  ) dut_pass (
    .clk(clk), .rst(rst),
    .data_in(p_data), .data_in_valid(p_valid), .data_in_ready(p_in_ready),
    .data_out(p_out_data), .data_out_valid(p_out_valid), .data_out_ready(p_out_ready),
    .frame_done(p_fd), .pad_error(p_pad_error)
  );

  // ---------------- scoreboard state ----------------
  int            checks = 0, errors = 0;
  logic [DW-1:0] exp_q[$];
  int            in_idx = 0, out_cnt = 0, fd_cnt = 0;
  logic [DW-1:0] first_out = '0, last_out = '0;
  logic          exp_fd = 1'b0, exp_pad = 1'b0;
  int            p_idx = 0;
  logic          p_prev_fire = 1'b0, p_exp_fd = 1'b0;
  logic [DW-1:0] p_prev_data = '0;

  function automatic bit is_interior(input int pos);
    int x, y;
    x = (pos / CH) % PWT;
    y = pos / (CH * PWT);
    return (x >= PW) && (x < PW + IW) && (y >= PH) && (y < PH + IH);
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process, evaluated mid-cycle when all inputs and outputs are settled.
  always @(negedge clk) begin
    int pos;
    bit interior, in_fire, p_fire;
    #1;
    if (!rst) begin
      check("rst_out_valid", data_out_valid, 1'b0);
      check("rst_data_out", data_out, '0);
      check("rst_frame_done", frame_done, 1'b0);
      check("rst_pad_error", pad_error, 1'b0);
      check("rst_p_out_valid", p_out_valid, 1'b0);
      exp_q.delete();
      in_idx = 0; exp_fd = 1'b0; exp_pad = 1'b0;
      p_idx = 0; p_prev_fire = 1'b0; p_exp_fd = 1'b0;
    end else begin
      pos      = in_idx % FRAME;
      interior = is_interior(pos);
      check("out_valid", data_out_valid, exp_q.size() != 0);
      if (data_out_valid && exp_q.size() != 0) begin
        check("out_data", data_out, exp_q[0]);
        if (data_out_ready) begin
          if (out_cnt == 0) first_out = exp_q[0];
          last_out = exp_q[0];
          out_cnt++;
          void'(exp_q.pop_front());
        end
      end
      if (!interior) check("border_ready", data_in_ready, 1'b1);
      check("frame_done", frame_done, exp_fd);
      check("pad_error", pad_error, exp_pad);
      if (frame_done) fd_cnt++;
      in_fire = data_in_valid && data_in_ready;
      exp_fd  = in_fire && (pos == FRAME - 1);
      if (in_fire) begin
        if (interior) exp_q.push_back(data_in);
`ifdef UNPADDING_ZERO_CHECK_EN
        else if (data_in != '0) exp_pad = 1'b1;
`endif
        in_idx++;
      end

      check("p_in_ready", p_in_ready, 1'b1);
      check("p_out_valid", p_out_valid, p_prev_fire);
      if (p_prev_fire) check("p_out_data", p_out_data, p_prev_data);
      check("p_frame_done", p_fd, p_exp_fd);
      check("p_pad_error", p_pad_error, 1'b0);
      p_fire      = p_valid && p_in_ready;
      p_exp_fd    = p_fire && ((p_idx % PFRAME) == PFRAME - 1);
      if (p_fire) p_idx++;
      p_prev_fire = p_fire;
      p_prev_data = p_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; data_in_valid = 1'b0; data_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic reset_counts();
    out_cnt = 0; fd_cnt = 0; first_out = '0; last_out = '0;
  endtask

  task automatic run_stream(input int n, input bit rnd_valid, input int stall_start,
                            input int stall_len, input bit rnd_ready, input int bad_idx,
                            input bit rnd_data);
    int sent = 0, cyc = 0, pos;
    while (sent < n && cyc < 4000) begin
      @(negedge clk);
      pos = sent % FRAME;
      data_in_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      if (is_interior(pos)) data_in = rnd_data ? $urandom : DW'(pos + 1);
      else                  data_in = (pos == bad_idx) ? 32'hDEAD : '0;
      if (rnd_ready) data_out_ready = 1'($urandom_range(0, 1));
      else data_out_ready = !(stall_start >= 0 && cyc >= stall_start && cyc < stall_start + stall_len);
      #1;
      if (data_in_valid && data_in_ready) sent++;
      cyc++;
    end
    if (sent < n) begin
      checks++; errors++;
      $display("FAIL stream_timeout: got %0d elements accepted expected %0d", sent, n);
    end
    @(negedge clk);
    data_in_valid = 1'b0;
  endtask

  task automatic drain();
    int cyc = 0;
    data_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    while (exp_q.size() != 0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    check("drain_empty", DW'(exp_q.size()), '0);
  endtask

  // Free-running stimulus for the zero-padding instance.
  initial begin
    p_valid = 1'b0; p_data = '0;
    forever begin
      @(negedge clk);
      p_valid = ($urandom_range(0, 3) != 0);
      p_data  = $urandom;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    data_in = '0; data_in_valid = 1'b0; data_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Sequential frame, downstream always ready.
    reset_counts();
    run_stream(FRAME, 1'b0, -1, 0, 1'b0, -1, 1'b0);
    drain();
    check("a_out_count", DW'(out_cnt), DW'(24));
    check("a_first_out", first_out, DW'(37));
    check("a_last_out", last_out, DW'(76));
    check("a_frame_done_count", DW'(fd_cnt), DW'(1));

    // Same frame with a 10-cycle downstream stall mid-frame.
    reset_counts();
    run_stream(FRAME, 1'b0, 40, 10, 1'b0, -1, 1'b0);
    drain();
    check("b_out_count", DW'(out_cnt), DW'(24));
    check("b_first_out", first_out, DW'(37));
    check("b_last_out", last_out, DW'(76));
    check("b_frame_done_count", DW'(fd_cnt), DW'(1));

    // Reset after 50 inputs, then a fresh frame.
    run_stream(50, 1'b0, -1, 0, 1'b0, -1, 1'b0);
    do_reset();
    reset_counts();
    run_stream(FRAME, 1'b0, -1, 0, 1'b0, -1, 1'b0);
    drain();
    check("c_out_count", DW'(out_cnt), DW'(24));
    check("c_first_out", first_out, DW'(37));
    check("c_frame_done_count", DW'(fd_cnt), DW'(1));

    // Non-zero value at border index 5.
    reset_counts();
    run_stream(FRAME, 1'b0, -1, 0, 1'b0, 5, 1'b0);
    drain();
`ifdef UNPADDING_ZERO_CHECK_EN
    check("d_pad_error_sticky", pad_error, 1'b1);
`else
    check("d_pad_error_off", pad_error, 1'b0);
`endif
    check("d_out_count", DW'(out_cnt), DW'(24));
    do_reset();

    // Random valid/ready over three back-to-back frames.
    reset_counts();
    run_stream(3 * FRAME, 1'b1, -1, 0, 1'b1, -1, 1'b1);
    drain();
    check("e_out_count", DW'(out_cnt), DW'(72));
    check("e_frame_done_count", DW'(fd_cnt), DW'(3));

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/unpadding.md
# unpadding

Stream cropper that removes a fixed zero border from a channel-interleaved image stream, the inverse of the padding stage. It accepts a padded frame of (IMG_WIDTH+2·PADDING_WIDTH) × (IMG_HEIGHT+2·PADDING_HEIGHT) × CHANNELS elements. It discards every border element and forwards only the interior IMG_WIDTH × IMG_HEIGHT × CHANNELS elements through a registered valid/ready output. It sits after padded convolution-style stages whose output must return to the unpadded geometry.

## Interface
- DATA_WIDTH, 32, element width
- IMG_WIDTH, 4, interior width in pixels
- IMG_HEIGHT, 3, interior height in pixels
- PADDING_WIDTH, 2, border columns on each side (0 allowed)
- PADDING_HEIGHT, 2, border rows on each side (0 allowed)
- CHANNELS, 2, elements per pixel (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- data_in  in  DATA_WIDTH  padded stream element
- data_in_valid  in  1  element valid
- data_in_ready  out  1  element accepted when high with valid
- data_out  out  DATA_WIDTH  interior element
- data_out_valid  out  1  output valid
- data_out_ready  in  1  downstream ready
- frame_done  out  1  one-cycle pulse on acceptance of the last padded element
- pad_error  out  1  sticky: non-zero border element seen (see Configuration)

## Operation
- Stream order: channel fastest, then x, then y; counters count_c, count_x, count_y track the position of the next input element.
- Counters advance only on data_in_valid && data_in_ready. Wrap order: c to CHANNELS-1 → 0 with x+1; x at padded width-1 → 0 with y+1; the last element of the frame clears all three.
- Border condition: x < PADDING_WIDTH, or x > PADDING_WIDTH+IMG_WIDTH-1, or y < PADDING_HEIGHT, or y > PADDING_HEIGHT+IMG_HEIGHT-1.
- Border element: data_in_ready = 1 regardless of data_out_ready. The element is consumed and dropped.
- Interior element: data_in_ready = skid buffer input ready. The element is pushed into the output slice unmodified.
- Comparisons are unsigned. Counter widths are $clog2(padded extent)+1, so there is no overflow at wrap.
- All padding = 0: pure pass-through with one-cycle registered latency.
- Reset asserted mid-frame: counters, the slice, frame_done, and pad_error all clear. The next accepted element is treated as frame position (0,0,0).

## Timing
- Reset values: data_out_valid = 0, data_out = 0, frame_done = 0, pad_error = 0, counters = 0.
- data_in_ready has a combinational path from the border decode and the skid buffer ready only. It has no path from data_in_valid.
- Latency: an interior element accepted in cycle N appears on data_out_valid in cycle N+1.
- Throughput: 1 element/cycle sustained in and out, with downstream always ready.
- Stall rule: data_out_valid held high with data_out stable until data_out_ready. The skid buffer absorbs one extra element, so a stall only backpressures the input on the next interior element.
- frame_done is registered and goes high the cycle after the last padded element handshake.
- Back-to-back frames: there is no idle cycle between frames, and frame_done coincides with the first handshake of the next frame.

## Configuration
- UNPADDING_ZERO_CHECK_EN defined: each accepted border element with data_in ≠ 0 sets pad_error in the following cycle. pad_error stays set until reset.
- Not defined: pad_error is tied to 0 and no comparator is built. The port is always present.

## Structure
- Package unpadding_pkg: a coordinate-width helper function (clog2(n)+1) shared with padding, plus a typedef for the 3-state frame position enum used by the border decode: TOP_BOTTOM, SIDE, INTERIOR.
- Sub-module: the existing skid_buffer, instantiated with DATA_WIDTH, forms the output register slice.

## Test plan
- Defaults, 112 sequential inputs (value = index+1 in the interior, 0 in the border), downstream always ready → exactly 24 outputs in order. The first output equals element (x=2, y=2, c=0), index 36. frame_done pulses once, after input 112.
- Same stimulus with data_out_ready held low for 10 cycles mid-frame → no loss or duplication. data_in_ready stays high on border elements during the stall. The output order is unchanged.
- PADDING_WIDTH = PADDING_HEIGHT = 0, 24 inputs → 24 identical outputs, each one cycle after its input.
- Reset pulsed after 50 inputs, then a full 112-element frame → exactly 24 outputs from the new frame. No residue from the first frame appears.
- With UNPADDING_ZERO_CHECK_EN, inject 0xDEAD at border index 5 → pad_error rises the next cycle and stays high through the frame. Without the macro, pad_error stays 0.
- Random valid/ready toggling over 3 back-to-back frames → 72 outputs matching the reference model. frame_done pulses 3 times.
